// File: rtl/config_bus_arbiter.sv
// -----------------------------------------------------------------------------
// config_bus_arbiter
//   Shares one Config-style read/write bus (r_en / w_en / write_data /
//   read_data) between NUM_REQ requesters. One transaction is in flight at a
//   time. The bus side issues a single-cycle strobe, waits RD_LATENCY cycles
//   for read data, and the owner then receives a single-cycle response pulse.
//
//   Arbitration is round-robin by default: the most recently granted requester
//   has the lowest priority. Define CFG_ARB_FIXED_PRIO_EN to use fixed priority
//   instead (lowest index wins, no round-robin pointer). Timing is the same in
//   both modes.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  bus data width
//   RD_LATENCY  cycles from the bus_r_en strobe until bus_read_data is valid (1..4)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active high
//   req_valid      per-requester request, held until its req_ready
//   req_write      per-requester 1=write / 0=read, sampled at handshake
//   req_wdata      per-requester write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      one-hot grant (combinational, only in IDLE)
//   rsp_valid      one-cycle completion pulse to the owner
//   rsp_rdata      read data (0 after a write), valid with rsp_valid, held otherwise
//   bus_r_en       read strobe to slave
//   bus_w_en       write strobe to slave
//   bus_write_data write data to slave, held until the next grant
//   bus_read_data  read data from slave
//   busy           high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module config_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          bus_r_en,
    output logic                          bus_w_en,
    output logic [DATA_WIDTH-1:0]         bus_write_data,
    input  logic [DATA_WIDTH-1:0]         bus_read_data,
    output logic                          busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q;
    logic [IW-1:0]         owner_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  rd_q;
    logic                  wr_q;
    logic [NUM_REQ-1:0]    rsp_q;
`ifndef CFG_ARB_FIXED_PRIO_EN
    logic [IW-1:0]         last_q;
`endif

    // Per-requester view of the flat write-data bus.
    logic [DATA_WIDTH-1:0] wd [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign wd[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grant selection. In round-robin mode the search starts just after the
    // last winner and wraps, so the last winner is examined last.
    logic                  hs_d;
    logic [IW-1:0]         sel_d;
    logic                  sel_write_d;
    logic [DATA_WIDTH-1:0] sel_wdata_d;

    always_comb begin
        int idx;
        idx         = 0;
        hs_d        = 1'b0;
        sel_d       = '0;
        sel_write_d = 1'b0;
        sel_wdata_d = '0;
        req_ready   = '0;
        if (state_q == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CFG_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = int'(last_q) + 1 + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
                if (!hs_d && req_valid[IW'(idx)]) begin
                    hs_d        = 1'b1;
                    sel_d       = IW'(idx);
                    sel_write_d = req_write[IW'(idx)];
                    sel_wdata_d = wd[IW'(idx)];
                end
            end
            if (hs_d) req_ready[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rsp_q   <= '0;
`ifndef CFG_ARB_FIXED_PRIO_EN
            last_q  <= IW'(NUM_REQ - 1);
`endif
        end else begin
            // Strobes and response are single-cycle pulses by default.
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            rsp_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (hs_d) begin
                        owner_q <= sel_d;
                        write_q <= sel_write_d;
                        wdata_q <= sel_wdata_d;
                        wr_q    <= sel_write_d;
                        rd_q    <= !sel_write_d;
`ifndef CFG_ARB_FIXED_PRIO_EN
                        last_q  <= sel_d;
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_q) begin
                        rsp_q[owner_q] <= 1'b1;
                        rdata_q        <= '0;
                        state_q        <= RESP;
                    end else begin
                        cnt_q   <= CW'(RD_LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Count 0 is the cycle in which the slave data is valid.
                    if (cnt_q == '0) begin
                        rdata_q        <= bus_read_data;
                        rsp_q[owner_q] <= 1'b1;
                        state_q        <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_q;
    assign rsp_rdata      = rdata_q;
    assign bus_r_en       = rd_q;
    assign bus_w_en       = wr_q;
    assign bus_write_data = wdata_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_config_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_config_bus_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   reference model. The DUT runs with RD_LATENCY=3. Inputs change just after
//   the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_config_bus_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int RDL = 3;
    localparam int OW  = 2*N + 2*DW + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, bus_write_data, bus_read_data;
    logic [DW-1:0]   rnd_data, slave_val;
    logic            bus_r_en, bus_w_en, busy, rnd_mode;
    logic [RDL-1:0]  rpipe = '0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    config_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_r_en(bus_r_en), .bus_w_en(bus_w_en), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .busy(busy)
    );

    // Slave: data valid only in the cycle RDL cycles after the strobe.
    always @(posedge clk) rpipe <= {rpipe[RDL-2:0], bus_r_en};
    assign bus_read_data = rnd_mode ? rnd_data : (rpipe[RDL-1] ? slave_val : 8'hEE);

    wire [OW-1:0] act = {req_ready, rsp_valid, rsp_rdata, bus_r_en, bus_w_en, bus_write_data, busy};

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = '0; req_write = '0; req_wdata = '0; rnd_mode = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    // ---------------- reference model (transaction phases) ----------------
    bit           m_txn, m_wr;
    int           m_phase, m_owner, m_last;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [N-1:0] e_ready;
    logic [OW-1:0] e_vec;

    task automatic m_reset();
        m_txn = 0; m_wr = 0; m_phase = 0; m_owner = 0; m_last = N - 1;
        m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_out();
        logic [N-1:0] rdy, rv;
        int ix;
        rdy = '0; rv = '0;
        if (!m_txn)
            for (int k = 0; k < N; k++) begin
`ifdef CFG_ARB_FIXED_PRIO_EN
                ix = k;
`else
                ix = (m_last + 1 + k) % N;
`endif
                if (rdy == '0 && req_valid[ix]) rdy[ix] = 1'b1;
            end
        if (m_txn && m_phase == (m_wr ? 2 : 2 + RDL)) rv[m_owner] = 1'b1;
        e_ready = rdy;
        e_vec = {rdy, rv, m_rdata, m_txn && m_phase == 1 && !m_wr,
                 m_txn && m_phase == 1 && m_wr, m_wdata, m_txn};
    endtask

    task automatic model_adv();
        if (rst) begin m_reset(); return; end
        if (m_txn) begin
            if (m_phase == (m_wr ? 1 : 1 + RDL)) m_rdata = m_wr ? '0 : bus_read_data;
            m_phase++;
            if (m_phase >= (m_wr ? 3 : 3 + RDL)) m_txn = 0;
        end else if (e_ready != '0) begin
            for (int k = 0; k < N; k++) if (e_ready[k]) m_owner = k;
            m_wr = req_write[m_owner]; m_wdata = req_wdata[m_owner*DW +: DW];
            m_last = m_owner; m_txn = 1; m_phase = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_write = '0; req_wdata = '0; rnd_mode = 1'b0;
        nxt(); nxt(); smp();
        n_chk++; if (act !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", act); end
        nxt(); rst = 1'b0; req_valid = '1;
        smp();
        n_chk++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_winner: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_write();
        reset_dut();
        req_valid = 4'b0100; req_write = 4'b0100; req_wdata[2*DW +: DW] = 8'hA5;
        smp();
        n_chk++; if (req_ready !== 4'b0100 || busy !== 1'b0) begin n_bad++; $display("FAIL wr_grant: got rdy=%b busy=%b want 0100/0", req_ready, busy); end
        nxt(); req_valid = '0;
        smp();
        n_chk++; if ({bus_w_en, bus_r_en, bus_write_data} !== {2'b10, 8'hA5}) begin n_bad++; $display("FAIL wr_issue: got w=%b r=%b d=%h want 1/0/a5", bus_w_en, bus_r_en, bus_write_data); end
        nxt(); smp();
        n_chk++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h00 || bus_w_en !== 1'b0) begin n_bad++; $display("FAIL wr_resp: got v=%b d=%h w=%b want 0100/00/0", rsp_valid, rsp_rdata, bus_w_en); end
        nxt(); smp();
        n_chk++; if (busy !== 1'b0 || rsp_valid !== '0 || bus_write_data !== 8'hA5) begin n_bad++; $display("FAIL wr_done: got busy=%b v=%b d=%h want 0/0000/a5", busy, rsp_valid, bus_write_data); end
    endtask

    task automatic test_read_latency();
        int nr = 0, nw = 0;
        reset_dut(); slave_val = 8'h3C;
        req_valid = 4'b1000; req_write = '0;
        smp();
        n_chk++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rd_grant: got %b want 1000", req_ready); end
        nxt(); req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            smp();
            nr += int'(bus_r_en); nw += int'(bus_w_en);
            if (c == 1) begin n_chk++; if (bus_r_en !== 1'b1) begin n_bad++; $display("FAIL rd_strobe: got %b want 1", bus_r_en); end end
            if (c == 4) begin n_chk++; if (rsp_valid !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL rd_wait: got v=%b busy=%b want 0000/1", rsp_valid, busy); end end
            if (c == 5) begin n_chk++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_resp: got v=%b d=%h want 1000/3c", rsp_valid, rsp_rdata); end end
            if (c == 6) begin n_chk++; if (busy !== 1'b0 || rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_hold: got busy=%b d=%h want 0/3c", busy, rsp_rdata); end end
            nxt();
        end
        n_chk++; if (nr != 1 || nw != 0) begin n_bad++; $display("FAIL rd_pulses: got r=%0d w=%0d want 1/0", nr, nw); end
    endtask

    task automatic test_round_robin();
        int own[$];
        int when[$];
        int ex;
        reset_dut();
        req_valid = '1; req_write = '1;
        for (int i = 0; i < N; i++) req_wdata[i*DW +: DW] = DW'(8'h10 + i);
        for (int c = 0; c < 15; c++) begin
            smp();
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) own.push_back(i);
                when.push_back(c);
            end
            if (c % 3 == 1 && own.size() > 0) begin
                n_chk++;
                if (bus_w_en !== 1'b1 || bus_write_data !== DW'(8'h10 + own[own.size()-1])) begin
                    n_bad++; $display("FAIL rr_wdata c=%0d: got w=%b d=%h want 1/%h", c, bus_w_en, bus_write_data, DW'(8'h10 + own[own.size()-1]));
                end
            end
            nxt();
        end
        req_valid = '0;
        n_chk++; if (own.size() != 5 || when.size() != 5) begin n_bad++; $display("FAIL rr_count: got %0d want 5", own.size()); end
        for (int k = 0; k < 5 && k < own.size() && k < when.size(); k++) begin
`ifdef CFG_ARB_FIXED_PRIO_EN
            ex = 0;
`else
            ex = k % N;
`endif
            n_chk++;
            if (own[k] != ex || when[k] != 3*k) begin n_bad++; $display("FAIL rr_order k=%0d: got req=%0d cyc=%0d want req=%0d cyc=%0d", k, own[k], when[k], ex, 3*k); end
        end
    endtask

    task automatic test_reset_mid_read();
        reset_dut(); slave_val = 8'h5A;
        req_valid = 4'b0010; req_write = '0;
        smp();
        n_chk++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rmr_grant: got %b want 0010", req_ready); end
        nxt(); req_valid = '0;
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        smp();
        n_chk++; if (act !== '0) begin n_bad++; $display("FAIL rmr_cleared: got %h want 0", act); end
        nxt(); req_valid = 4'b1010; req_write = 4'b1010; req_wdata = '0;
        smp();
        n_chk++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rmr_ptr: got %b want 0010", req_ready); end
        nxt(); req_valid = 4'b1000;
        smp();
        n_chk++; if (rsp_valid !== '0 || bus_w_en !== 1'b1) begin n_bad++; $display("FAIL rmr_issue: got v=%b w=%b want 0000/1", rsp_valid, bus_w_en); end
        nxt(); smp();
        n_chk++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rmr_resp: got v=%b d=%h want 0010/00", rsp_valid, rsp_rdata); end
        nxt(); smp();
        n_chk++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rmr_next: got %b want 1000", req_ready); end
        nxt(); req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int ovl = 0;
        reset_dut(); slave_val = 8'h77;
        req_valid = 4'b0001; req_write = 4'b0001; req_wdata = 32'h0000_0011;
        smp();
        n_chk++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_grant1: got %b want 0001", req_ready); end
        nxt(); req_write = '0;
        for (int c = 1; c <= 9; c++) begin
            smp();
            if (bus_r_en && bus_w_en) ovl++;
            if (c == 1) begin n_chk++; if (bus_w_en !== 1'b1 || bus_write_data !== 8'h11 || req_ready !== '0) begin n_bad++; $display("FAIL b2b_wr: got w=%b d=%h rdy=%b want 1/11/0000", bus_w_en, bus_write_data, req_ready); end end
            if (c == 2) begin n_chk++; if (rsp_valid !== 4'b0001 || req_ready !== '0) begin n_bad++; $display("FAIL b2b_wrsp: got v=%b rdy=%b want 0001/0000", rsp_valid, req_ready); end end
            if (c == 3) begin n_chk++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_grant2: got %b want 0001", req_ready); end end
            if (c == 4) begin n_chk++; if (bus_r_en !== 1'b1 || bus_w_en !== 1'b0) begin n_bad++; $display("FAIL b2b_rd: got r=%b w=%b want 1/0", bus_r_en, bus_w_en); end end
            if (c == 8) begin n_chk++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h77) begin n_bad++; $display("FAIL b2b_rrsp: got v=%b d=%h want 0001/77", rsp_valid, rsp_rdata); end end
            nxt();
            if (c == 3) req_valid = '0;
        end
        n_chk++; if (ovl != 0) begin n_bad++; $display("FAIL b2b_overlap: got %0d want 0", ovl); end
    endtask

    task automatic test_random();
        reset_dut(); rnd_mode = 1'b1; m_reset();
        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            req_write = N'($urandom);
            req_wdata = $urandom;
            rnd_data  = DW'($urandom);
            rst       = ($urandom_range(0, 59) == 0);
            smp();
            model_out();
            n_chk++; if (act !== e_vec) begin n_bad++; $display("FAIL random c=%0d: got %h want %h", c, act, e_vec); end
            model_adv();
            nxt();
        end
        rst = 1'b0; req_valid = '0; rnd_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_wdata = '0;
        rnd_mode = 1'b0; rnd_data = '0; slave_val = '0;
        test_reset();
        test_single_write();
        test_read_latency();
        test_round_robin();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
